// File: rtl/sprite_mover_if.sv
// Signal bundle between the frame/tick sources and the sprite mover.
interface sprite_mover_if;
    logic       tick;
    logic       run;
    logic       vblank;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       dir_x;
    logic       dir_y;
    logic       bounce;
    logic       overrun;

    modport master (
        output tick, run, vblank,
        input  x_pos, y_pos, dir_x, dir_y, bounce, overrun
    );

    modport slave (
        input  tick, run, vblank,
        output x_pos, y_pos, dir_x, dir_y, bounce, overrun
    );
endinterface

// File: rtl/sprite_mover.sv
// Bouncing sprite position: a tick requests one step, applied one cycle after the next vblank.
// No backpressure: requests coalesce while pending, the sticky overrun flag records the excess.
module sprite_mover #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 2,
    parameter int INIT_X   = 0,
    parameter int INIT_Y   = 0
) (
    input logic           clk,
    input logic           reset,
    sprite_mover_if.slave bus
);
    localparam int LIM_X = SCREEN_W - SPR_W;
    localparam int LIM_Y = SCREEN_H - SPR_H;

    typedef enum logic [1:0] {IDLE, PENDING, UPDATE} state_t;

    state_t     state_q;
    logic [9:0] x_q, y_q;
    logic       dir_x_q, dir_y_q, bounce_q, overrun_q;

    logic [9:0] x_d, y_d;
    logic       dir_x_d, dir_y_d, bounce_x, bounce_y;

    // One axis step, returns {reflected, new_dir, new_pos}; 11-bit compares avoid wrap.
    function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic dir,
                                              input int step, input int lim);
        logic [10:0] pos_ext;
        pos_ext = {1'b0, pos};
        if (dir) begin
            if (pos_ext + 11'(step) >= 11'(lim))
                axis_next = {1'b1, 1'b0, 10'(lim)};
            else
                axis_next = {1'b0, 1'b1, pos + 10'(step)};
        end else begin
            if (pos_ext <= 11'(step))
                axis_next = {1'b1, 1'b1, 10'd0};
            else
                axis_next = {1'b0, 1'b0, pos - 10'(step)};
        end
    endfunction

    always_comb begin
        {bounce_x, dir_x_d, x_d} = axis_next(x_q, dir_x_q, STEP_X, LIM_X);
        {bounce_y, dir_y_d, y_d} = axis_next(y_q, dir_y_q, STEP_Y, LIM_Y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= 10'(INIT_X);
            y_q       <= 10'(INIT_Y);
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            bounce_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            bounce_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A vblank coinciding with the tick is deliberately not used.
                    if (bus.tick && bus.run)
                        state_q <= PENDING;
                end
                PENDING: begin
                    if (bus.tick && bus.run)
                        overrun_q <= 1'b1;
                    if (!bus.run)
                        state_q <= IDLE;
                    else if (bus.vblank)
                        state_q <= UPDATE;
                end
                UPDATE: begin
                    x_q      <= x_d;
                    y_q      <= y_d;
                    dir_x_q  <= dir_x_d;
                    dir_y_q  <= dir_y_d;
                    bounce_q <= bounce_x | bounce_y;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x_pos   = x_q;
    assign bus.y_pos   = y_q;
    assign bus.dir_x   = dir_x_q;
    assign bus.dir_y   = dir_y_q;
    assign bus.bounce  = bounce_q;
    assign bus.overrun = overrun_q;
endmodule
